// File: rtl/mmio_bus_sel_if.sv
// MEM-stage bus between the mini_rv pipeline, data_mem and the MMIO selector.
//   addr   byte address (alu_c)        we     store enable
//   wdata  store data (rf_rD2)         rdata  load data back to MEM stage
//   dm_we  data_mem write enable       dm_rd  data_mem async read data
// master: pipeline/data_mem side; slave: the selector.
interface mmio_bus_sel_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dm_we;
  logic [31:0] dm_rd;

  modport master (
    output addr, we, wdata, dm_rd,
    input  rdata, dm_we
  );

  modport slave (
    input  addr, we, wdata, dm_rd,
    output rdata, dm_we
  );
endinterface

// File: rtl/mmio_bus_sel.sv
// Memory-mapped I/O selector between the MEM-stage bus and data_mem.
// Accesses with addr[31:12]==IO_PAGE hit the internal I/O page (SEG, LED,
// synchronised switches, prescaled compare timer); everything else goes to
// DRAM. Read path is combinational so MEM-stage loads keep same-cycle timing.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   bus (slave)   addr/we/wdata/rdata/dm_we/dm_rd
//   sw_i          asynchronous switch pins (SW_W)
//   led_o         LED register (LED_W)
//   seg_o         seven-segment data register (32)
//   tmr_flag_o    sticky timer compare flag
// I/O map (offset, addr[1:0] ignored):
//   0x000 SEG  0x060 LED  0x070 SW(RO)  0x080 CNT  0x084 CMP
//   0x088 CTRL bit0 EN, bit1 FLAG (W1C)
module mmio_bus_sel #(
  parameter logic [19:0] IO_PAGE  = 20'hFFFFF,
  parameter int unsigned SW_W     = 24,
  parameter int unsigned LED_W    = 24,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_bus_sel_if.slave        bus,
  input  logic [SW_W-1:0]      sw_i,
  output logic [LED_W-1:0]     led_o,
  output logic [31:0]          seg_o,
  output logic                 tmr_flag_o
);

  localparam logic [9:0]  OFF_SEG  = 10'h000;
  localparam logic [9:0]  OFF_LED  = 10'h018;
  localparam logic [9:0]  OFF_SW   = 10'h01C;
  localparam logic [9:0]  OFF_CNT  = 10'h020;
  localparam logic [9:0]  OFF_CMP  = 10'h021;
  localparam logic [9:0]  OFF_CTRL = 10'h022;
  localparam logic [31:0] PS_LAST  = 32'(PRESCALE - 1);

  logic             io_sel;
  logic [9:0]       woff;
  logic             wr_io;
  logic             wr_ctrl;
  logic             tick;
  logic [31:0]      io_rd;
  logic             unused_addr_lsb;

  logic [31:0]      seg_q,   seg_d;
  logic [LED_W-1:0] led_q,   led_d;
  logic [31:0]      cnt_q,   cnt_d;
  logic [31:0]      cmp_q,   cmp_d;
  logic [31:0]      presc_q, presc_d;
  logic             en_q,    en_d;
  logic             flag_q,  flag_d;
  logic [SW_W-1:0]  sync_q [SYNC_STG];

  assign io_sel          = (bus.addr[31:12] == IO_PAGE);
  assign woff            = bus.addr[11:2];
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign wr_io           = bus.we & io_sel;
  assign wr_ctrl         = wr_io & (woff == OFF_CTRL);
  assign bus.dm_we       = bus.we & ~io_sel;

  // A same-cycle write of EN=0 suppresses the tick that would otherwise fire.
  assign tick = en_q && (presc_q == PS_LAST) && !(wr_ctrl && !bus.wdata[0]);

  always_comb begin
    io_rd = '0;
    case (woff)
      OFF_SEG:  io_rd = seg_q;
      OFF_LED:  io_rd[LED_W-1:0] = led_q;
      OFF_SW:   io_rd[SW_W-1:0] = sync_q[SYNC_STG-1];
      OFF_CNT:  io_rd = cnt_q;
      OFF_CMP:  io_rd = cmp_q;
      OFF_CTRL: io_rd[1:0] = {flag_q, en_q};
      default:  io_rd = '0;
    endcase
  end

  assign bus.rdata = io_sel ? io_rd : bus.dm_rd;

  always_comb begin
    seg_d   = seg_q;
    led_d   = led_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    presc_d = presc_q;

    if (wr_io && woff == OFF_SEG) seg_d = bus.wdata;
    if (wr_io && woff == OFF_LED) led_d = bus.wdata[LED_W-1:0];
    if (wr_io && woff == OFF_CMP) cmp_d = bus.wdata;
    if (wr_ctrl)                  en_d  = bus.wdata[0];

    if (!en_q || (wr_ctrl && !bus.wdata[0]))
      presc_d = '0;
    else if (presc_q == PS_LAST)
      presc_d = '0;
    else
      presc_d = presc_q + 32'd1;

    // Tick update first, then CPU write to CNT overrides it.
    if (tick) begin
      if (cnt_q == cmp_q) cnt_d = '0;
      else                cnt_d = cnt_q + 32'd1;
    end
    if (wr_io && woff == OFF_CNT) cnt_d = bus.wdata;

    // W1C clear first, then a same-cycle set wins.
    if (wr_ctrl && bus.wdata[1])   flag_d = 1'b0;
    if (tick && (cnt_q == cmp_q))  flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      led_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
      presc_q <= '0;
      for (int unsigned i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
    end else begin
      seg_q   <= seg_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      flag_q  <= flag_d;
      presc_q <= presc_d;
      sync_q[0] <= sw_i;
      for (int unsigned i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign led_o      = led_q;
  assign seg_o      = seg_q;
  assign tmr_flag_o = flag_q;

endmodule

// File: tb/tb_mmio_bus_sel.sv
// Directed bench for mmio_bus_sel: one PRESCALE=1 instance for the bus map
// and timer conflicts, one PRESCALE=3 instance for the prescaled period.
module tb_mmio_bus_sel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] sw  = '0;
  logic [23:0] led;
  logic [31:0] seg;
  logic        flag;
  logic [23:0] sw3 = '0;
  logic [23:0] led3;
  logic [31:0] seg3;
  logic        flag3;
  int          checks = 0;
  int          errors = 0;

  mmio_bus_sel_if bus ();
  mmio_bus_sel_if bus3 ();

  mmio_bus_sel #(
    .IO_PAGE(20'hFFFFF), .SW_W(24), .LED_W(24), .SYNC_STG(2), .PRESCALE(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .sw_i(sw),
    .led_o(led), .seg_o(seg), .tmr_flag_o(flag)
  );

  mmio_bus_sel #(
    .IO_PAGE(20'hFFFFF), .SW_W(24), .LED_W(24), .SYNC_STG(2), .PRESCALE(3)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sw_i(sw3),
    .led_o(led3), .seg_o(seg3), .tmr_flag_o(flag3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    step();
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 1'b0;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    rd(32'hFFFFF060, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_led_rd got=%h exp=%h", v, 32'h0); end
    rd(32'hFFFFF070, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sw_rd got=%h exp=%h", v, 32'h0); end
    rd(32'hFFFFF088, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl_rd got=%h exp=%h", v, 32'h0); end
    checks++; if (bus.dm_we !== 1'b0) begin errors++; $display("FAIL reset_dm_we got=%b exp=0", bus.dm_we); end
    checks++; if (led !== 24'h0) begin errors++; $display("FAIL reset_led_o got=%h exp=0", led); end
    checks++; if (seg !== 32'h0) begin errors++; $display("FAIL reset_seg_o got=%h exp=0", seg); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", flag); end
  endtask

  task automatic test_dram();
    logic [31:0] v;
    bus.addr  = 32'h0000_0100;
    bus.wdata = 32'h0000_1234;
    bus.we    = 1'b1;
    #1;
    checks++; if (bus.dm_we !== 1'b1) begin errors++; $display("FAIL dram_dm_we got=%b exp=1", bus.dm_we); end
    step();
    bus.we    = 1'b0;
    bus.dm_rd = 32'h0000_1234;
    rd(32'h0000_0100, v);
    checks++; if (v !== 32'h0000_1234) begin errors++; $display("FAIL dram_rdata got=%h exp=%h", v, 32'h1234); end
    // Just below the I/O page still routes to DRAM.
    bus.dm_rd = 32'h0000_0055;
    rd(32'hFFFFE060, v);
    checks++; if (v !== 32'h0000_0055) begin errors++; $display("FAIL page_edge_rdata got=%h exp=%h", v, 32'h55); end
  endtask

  task automatic test_led_seg();
    logic [31:0] v;
    bus.dm_rd = 32'hCAFE_F00D;
    bus.addr  = 32'hFFFFF060;
    bus.wdata = 32'hFFFF_ABCD;
    bus.we    = 1'b1;
    #1;
    checks++; if (bus.dm_we !== 1'b0) begin errors++; $display("FAIL io_dm_we got=%b exp=0", bus.dm_we); end
    step();
    bus.we = 1'b0;
    checks++; if (led !== 24'hFFABCD) begin errors++; $display("FAIL led_o got=%h exp=%h", led, 24'hFFABCD); end
    rd(32'hFFFFF060, v);
    checks++; if (v !== 32'h00FF_ABCD) begin errors++; $display("FAIL led_rd got=%h exp=%h", v, 32'h00FFABCD); end
    rd(32'hFFFFF063, v);
    checks++; if (v !== 32'h00FF_ABCD) begin errors++; $display("FAIL led_rd_lsb got=%h exp=%h", v, 32'h00FFABCD); end
    io_write(32'hFFFFF000, 32'hDEAD_BEEF);
    checks++; if (seg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL seg_o got=%h exp=%h", seg, 32'hDEADBEEF); end
    rd(32'hFFFFF000, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL seg_rd got=%h exp=%h", v, 32'hDEADBEEF); end
    io_write(32'hFFFFF070, 32'h0012_3456);
    rd(32'hFFFFF070, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_ro got=%h exp=0", v); end
    io_write(32'hFFFFF090, 32'h1111_1111);
    rd(32'hFFFFF090, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=0", v); end
    checks++; if (seg !== 32'hDEAD_BEEF || led !== 24'hFFABCD) begin
      errors++; $display("FAIL unmapped_side_effect seg=%h led=%h exp seg=deadbeef led=ffabcd", seg, led);
    end
  endtask

  task automatic test_sw();
    logic [31:0] v;
    sw = 24'h00A5A5;
    rd(32'hFFFFF070, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_edge0 got=%h exp=0", v); end
    step();
    rd(32'hFFFFF070, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL sw_edge1 got=%h exp=0", v); end
    step();
    rd(32'hFFFFF070, v);
    checks++; if (v !== 32'h0000_A5A5) begin errors++; $display("FAIL sw_edge2 got=%h exp=%h", v, 32'hA5A5); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    io_write(32'hFFFFF084, 32'd3);
    io_write(32'hFFFFF088, 32'd1);
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL tmr_cnt0 got=%0d exp=0", v); end
    for (int k = 1; k <= 3; k++) begin
      step();
      rd(32'hFFFFF080, v);
      checks++; if (v !== 32'(k)) begin errors++; $display("FAIL tmr_cnt%0d got=%0d exp=%0d", k, v, k); end
      checks++; if (flag !== 1'b0) begin errors++; $display("FAIL tmr_flag_early%0d got=%b exp=0", k, flag); end
    end
    step();
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL tmr_wrap got=%0d exp=0", v); end
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL tmr_flag_set got=%b exp=1", flag); end
    rd(32'hFFFFF088, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL tmr_ctrl_rd got=%h exp=3", v); end
    io_write(32'hFFFFF088, 32'd3);
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL tmr_w1c got=%b exp=0", flag); end
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL tmr_after_w1c got=%0d exp=1", v); end
    step();
    step();
    io_write(32'hFFFFF088, 32'd3);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL tmr_set_beats_w1c got=%b exp=1", flag); end
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL tmr_wrap2 got=%0d exp=0", v); end
  endtask

  task automatic test_cnt_write();
    logic [31:0] v;
    io_write(32'hFFFFF080, 32'd7);
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL cnt_wr_beats_tick got=%0d exp=7", v); end
    step();
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL cnt_after_wr got=%0d exp=8", v); end
    io_write(32'hFFFFF088, 32'd0);
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL en0_suppress got=%0d exp=8", v); end
    step();
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL en0_frozen got=%0d exp=8", v); end
    io_write(32'hFFFFF088, 32'd1);
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd8) begin errors++; $display("FAIL en1_first got=%0d exp=8", v); end
    step();
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL en1_count got=%0d exp=9", v); end
    // Reset mid-count, with a same-edge LED write that reset must override.
    rst       = 1'b1;
    bus.addr  = 32'hFFFFF060;
    bus.wdata = 32'h0000_0123;
    bus.we    = 1'b1;
    step();
    bus.we = 1'b0;
    rst    = 1'b0;
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", v); end
    rd(32'hFFFFF088, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_ctrl got=%h exp=0", v); end
    checks++; if (flag !== 1'b0) begin errors++; $display("FAIL rst_flag got=%b exp=0", flag); end
    checks++; if (led !== 24'h0) begin errors++; $display("FAIL rst_beats_wr got=%h exp=0", led); end
    step();
    rd(32'hFFFFF080, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_en_off got=%0d exp=0", v); end
  endtask

  task automatic test_prescale();
    logic [31:0] exp_cnt [6] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
    logic        exp_flg [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] v;
    bus3.addr  = 32'hFFFFF084;
    bus3.wdata = 32'd1;
    bus3.we    = 1'b1;
    step();
    bus3.addr  = 32'hFFFFF088;
    bus3.wdata = 32'd1;
    step();
    bus3.we    = 1'b0;
    bus3.addr  = 32'hFFFFF080;
    for (int k = 0; k < 6; k++) begin
      step();
      v = bus3.rdata;
      checks++; if (v !== exp_cnt[k]) begin errors++; $display("FAIL ps_cnt%0d got=%0d exp=%0d", k + 1, v, exp_cnt[k]); end
      checks++; if (flag3 !== exp_flg[k]) begin errors++; $display("FAIL ps_flag%0d got=%b exp=%b", k + 1, flag3, exp_flg[k]); end
    end
  endtask

  initial begin
    bus.addr   = '0;
    bus.we     = 1'b0;
    bus.wdata  = '0;
    bus.dm_rd  = '0;
    bus3.addr  = '0;
    bus3.we    = 1'b0;
    bus3.wdata = '0;
    bus3.dm_rd = '0;
    test_reset();
    test_dram();
    test_led_seg();
    test_sw();
    test_timer();
    test_cnt_write();
    test_prescale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
